// File: rtl/id_pkg.sv
// id_pkg -- shared decode definitions for the instruction-decode stage.
// Holds the RV32 opcode constants, the ALUOp encodings, the control
// bundle carried down the ID/EX register, and small decode helpers.
package id_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,   // address generation (loads/stores)
      ALU_SUB = 2'b01,   // branch compare
      ALU_FN  = 2'b10    // operation selected by funct fields
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    alu_src;
      logic    mem_write;
      logic    mem_read;
      logic    result_src;
      logic    branch;
      alu_op_e alu_op;
      logic    illegal;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
      ctrl_t c;
      c = '0;
      case (opc)
         OP_R:   begin c.reg_write = 1'b1; c.alu_op = ALU_FN; end
         OP_I:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_FN; end
         OP_LW:  begin
            c.reg_write  = 1'b1;
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.result_src = 1'b1;
            c.alu_op     = ALU_ADD;
         end
         OP_SW:  begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = ALU_ADD; end
         OP_BEQ: begin c.branch = 1'b1; c.alu_op = ALU_SUB; end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   function automatic logic uses_rs1(input logic [6:0] opc);
      return (opc == OP_R) || (opc == OP_I) || (opc == OP_LW) ||
             (opc == OP_SW) || (opc == OP_BEQ);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      return (opc == OP_R) || (opc == OP_SW) || (opc == OP_BEQ);
   endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile -- architectural register file, two read ports, one write port.
//   clk, rst      : clock, synchronous active-high reset (clears every register)
//   ra1/ra2       : read addresses; rd1/rd2 combinational read data
//   we/wa/wd      : write enable, address, data
// x0 and any address >= NREG read as zero. With BYPASS set, a read of the
// register being written this cycle returns the write data.
module id_regfile #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   localparam int         AW     = $clog2(NREG);
   localparam logic [5:0] NREG_L = 6'(NREG);

   logic [XLEN-1:0] regs [NREG];
   logic            wr_ok;

   // Writes to x0 or beyond the implemented register count are dropped.
   assign wr_ok = we && (wa != 5'd0) && ({1'b0, wa} < NREG_L);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wa[AW-1:0]] <= wd;
      end
   end

   function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
      if (a == 5'd0 || {1'b0, a} >= NREG_L) return '0;
      if (BYPASS != 0 && wr_ok && wa == a) return wd;
      return regs[a[AW-1:0]];
   endfunction

   always_comb rd1 = rd_port(ra1);
   always_comb rd2 = rd_port(ra2);

endmodule

// File: rtl/id_pipe.sv
// id_pipe -- instruction decode stage with ID/EX pipeline register.
//   clk, rst                 : clock, synchronous active-high reset
//   if_valid/if_instr/if_pc  : fetched instruction offer; id_ready accepts it
//   wb_we/wb_rd/wb_data      : register write-back port
//   flush                    : drop the held and incoming instruction
//   ex_ready                 : downstream takes the ID/EX contents
//   ex_*                     : ID/EX register (valid, pc, operands, fields, controls)
//   stall_cnt                : saturating count of load-use bubble cycles
module id_pipe
   import id_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   input  logic            ex_ready,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_dataA,
   output logic [XLEN-1:0] ex_dataB,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic            ex_RegWrite,
   output logic            ex_ALUSrc,
   output logic            ex_MemWrite,
   output logic            ex_MemRead,
   output logic            ex_ResultSrc,
   output logic            ex_Branch,
   output logic [1:0]      ex_ALUOp,
   output logic            ex_illegal,
   output logic [31:0]     stall_cnt
);

   localparam logic [5:0] NREG_L = 6'(NREG);

   logic [6:0]      opc;
   logic [4:0]      rs1, rs2, rd;
   logic            use1, use2;
   ctrl_t           dec_ctrl, ex_ctrl;
   logic [XLEN-1:0] dec_imm, rdata1, rdata2;
   logic            hazard, accept, stall_evt;
   logic            unused_funct3;

   assign opc  = if_instr[6:0];
   assign rd   = if_instr[11:7];
   assign rs1  = if_instr[19:15];
   assign rs2  = if_instr[24:20];
   assign use1 = uses_rs1(opc);
   assign use2 = uses_rs2(opc);

   // funct3 only matters to the ALU, which decodes it from elsewhere.
   assign unused_funct3 = ^if_instr[14:12];

   id_regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .ra2 (rs2),
      .rd1 (rdata1),
      .rd2 (rdata2),
      .we  (wb_we),
      .wa  (wb_rd),
      .wd  (wb_data)
   );

   always_comb begin
      dec_ctrl = decode_ctrl(opc);
      // A used source beyond the implemented registers makes the instruction illegal.
      if ((use1 && {1'b0, rs1} >= NREG_L) || (use2 && {1'b0, rs2} >= NREG_L))
         dec_ctrl.illegal = 1'b1;

      dec_imm = '0;
      case (opc)
         OP_I, OP_LW: dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
         OP_SW:       dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
         OP_BEQ:      dec_imm = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                                 if_instr[30:25], if_instr[11:8], 1'b0};
         default:     dec_imm = '0;
      endcase
   end

   // Load-use: the load in EX cannot forward its data in time for this read.
   assign hazard = ex_valid && ex_MemRead && (ex_rd != 5'd0) &&
                   ((use1 && ex_rd == rs1) || (use2 && ex_rd == rs2));

   assign id_ready  = !rst && (flush || (!hazard && (!ex_valid || ex_ready)));
   assign accept    = if_valid && id_ready && !flush;
   assign stall_evt = !flush && if_valid && hazard && ex_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid  <= 1'b0;
         ex_ctrl   <= '0;
         ex_pc     <= '0;
         ex_dataA  <= '0;
         ex_dataB  <= '0;
         ex_imm    <= '0;
         ex_rd     <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         stall_cnt <= '0;
      end else begin
         if (flush) begin
            ex_valid <= 1'b0;
         end else if (accept) begin
            ex_valid <= 1'b1;
            ex_ctrl  <= dec_ctrl;
            ex_pc    <= if_pc;
            ex_dataA <= rdata1;
            ex_dataB <= rdata2;
            ex_imm   <= dec_imm;
            ex_rd    <= rd;
            ex_rs1   <= rs1;
            ex_rs2   <= rs2;
         end else if (ex_ready) begin
            // Consumed with nothing behind it (or a load-use bubble).
            ex_valid <= 1'b0;
         end
         if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign ex_RegWrite  = ex_ctrl.reg_write;
   assign ex_ALUSrc    = ex_ctrl.alu_src;
   assign ex_MemWrite  = ex_ctrl.mem_write;
   assign ex_MemRead   = ex_ctrl.mem_read;
   assign ex_ResultSrc = ex_ctrl.result_src;
   assign ex_Branch    = ex_ctrl.branch;
   assign ex_ALUOp     = ex_ctrl.alu_op;
   assign ex_illegal   = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe -- directed and randomized checks of id_pipe against a
// behavioural model of the decode stage (register array, ID/EX contents,
// stall counter). A second instance built with NREG=16 covers RV32E limits.
module tb_id_pipe;

   logic        clk = 1'b0;
   logic        rst, if_valid, wb_we, flush, ex_ready;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  wb_rd;

   logic        id_ready, ex_valid, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead;
   logic        ex_ResultSrc, ex_Branch, ex_illegal;
   logic [1:0]  ex_ALUOp;
   logic [31:0] ex_pc, ex_dataA, ex_dataB, ex_imm, stall_cnt;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;

   logic        id_ready16, ex_valid16, ex_RegWrite16, ex_ALUSrc16, ex_MemWrite16, ex_MemRead16;
   logic        ex_ResultSrc16, ex_Branch16, ex_illegal16;
   logic [1:0]  ex_ALUOp16;
   logic [31:0] ex_pc16, ex_dataA16, ex_dataB16, ex_imm16, stall_cnt16;
   logic [4:0]  ex_rd16, ex_rs1_16, ex_rs2_16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_pipe #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_dataA(ex_dataA), .ex_dataB(ex_dataB), .ex_imm(ex_imm), .ex_rd(ex_rd),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_RegWrite(ex_RegWrite), .ex_ALUSrc(ex_ALUSrc),
      .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_ResultSrc(ex_ResultSrc),
      .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp), .ex_illegal(ex_illegal),
      .stall_cnt(stall_cnt));

   id_pipe #(.XLEN(32), .NREG(16), .BYPASS(1)) dut16 (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready16), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid16), .ex_pc(ex_pc16),
      .ex_dataA(ex_dataA16), .ex_dataB(ex_dataB16), .ex_imm(ex_imm16), .ex_rd(ex_rd16),
      .ex_rs1(ex_rs1_16), .ex_rs2(ex_rs2_16), .ex_RegWrite(ex_RegWrite16),
      .ex_ALUSrc(ex_ALUSrc16), .ex_MemWrite(ex_MemWrite16), .ex_MemRead(ex_MemRead16),
      .ex_ResultSrc(ex_ResultSrc16), .ex_Branch(ex_Branch16), .ex_ALUOp(ex_ALUOp16),
      .ex_illegal(ex_illegal16), .stall_cnt(stall_cnt16));

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        v;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rd, rs1, rs2;
      logic        rw, asrc, mw, mr, rsrc, br;
      logic [1:0]  aop;
      logic        ill;
   } exp_t;

   exp_t        m, mn;
   logic [31:0] m_regs [32];
   logic [31:0] m_stall, m_stall_n;
   bit          chk_all;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_we && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic bit is_op(input logic [31:0] ins, input logic [6:0] op);
      return ins[6:0] == op;
   endfunction

   function automatic bit reads_rs1(input logic [31:0] ins);
      return is_op(ins, 7'h33) || is_op(ins, 7'h13) || is_op(ins, 7'h03) ||
             is_op(ins, 7'h23) || is_op(ins, 7'h63);
   endfunction

   function automatic bit reads_rs2(input logic [31:0] ins);
      return is_op(ins, 7'h33) || is_op(ins, 7'h23) || is_op(ins, 7'h63);
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t        e;
      logic [11:0] f12;
      logic [12:0] f13;
      e     = '0;
      e.v   = 1'b1;
      e.pc  = pc;
      e.rd  = ins[11:7];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.a   = ref_read(e.rs1);
      e.b   = ref_read(e.rs2);
      case (ins[6:0])
         7'h33: begin e.rw = 1; e.aop = 2'd2; end
         7'h13: begin
            e.rw = 1; e.asrc = 1; e.aop = 2'd2;
            f12 = ins[31:20]; e.imm = 32'(int'($signed(f12)));
         end
         7'h03: begin
            e.rw = 1; e.asrc = 1; e.mr = 1; e.rsrc = 1; e.aop = 2'd0;
            f12 = ins[31:20]; e.imm = 32'(int'($signed(f12)));
         end
         7'h23: begin
            e.asrc = 1; e.mw = 1; e.aop = 2'd0;
            f12 = {ins[31:25], ins[11:7]}; e.imm = 32'(int'($signed(f12)));
         end
         7'h63: begin
            e.br = 1; e.aop = 2'd1;
            f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            e.imm = 32'(int'($signed(f13)));
         end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   // One clock: predict, check id_ready, clock, check ID/EX contents.
   task automatic cyc();
      bit hz, rdy;
      #1;
      hz  = m.v && m.mr && m.rd != 5'd0 &&
            ((reads_rs1(if_instr) && m.rd == if_instr[19:15]) ||
             (reads_rs2(if_instr) && m.rd == if_instr[24:20]));
      rdy = !rst && (flush || (!hz && (!m.v || ex_ready)));
      chk("id_ready", {63'd0, id_ready}, {63'd0, rdy});
      mn        = m;
      m_stall_n = m_stall;
      chk_all   = 0;
      if (rst) begin
         mn        = '0;
         m_stall_n = 0;
         chk_all   = 1;
         for (int i = 0; i < 32; i++) m_regs[i] = 0;
      end else begin
         if (flush) mn.v = 0;
         else if (if_valid && rdy) mn = ref_decode(if_instr, if_pc);
         else if (ex_ready) mn.v = 0;
         if (!flush && if_valid && hz && ex_ready && m_stall != 32'hFFFF_FFFF)
            m_stall_n = m_stall + 1;
         if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      end
      @(posedge clk);
      #1;
      m       = mn;
      m_stall = m_stall_n;
      chk("ex_valid", {63'd0, ex_valid}, {63'd0, m.v});
      chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
      if (m.v || chk_all) begin
         chk("ex_pc", {32'd0, ex_pc}, {32'd0, m.pc});
         chk("ex_dataA", {32'd0, ex_dataA}, {32'd0, m.a});
         chk("ex_dataB", {32'd0, ex_dataB}, {32'd0, m.b});
         chk("ex_imm", {32'd0, ex_imm}, {32'd0, m.imm});
         chk("ex_fields", {49'd0, ex_rd, ex_rs1, ex_rs2}, {49'd0, m.rd, m.rs1, m.rs2});
         chk("ex_ctrl", {55'd0, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead,
                         ex_ResultSrc, ex_Branch, ex_ALUOp, ex_illegal},
                        {55'd0, m.rw, m.asrc, m.mw, m.mr, m.rsrc, m.br, m.aop, m.ill});
      end
   endtask

   function automatic logic [4:0] rand_reg();
      if ($urandom_range(0, 3) == 0) return 5'($urandom);
      return 5'($urandom_range(0, 3));
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] opc;
      case ($urandom_range(0, 6))
         0: opc = 7'h33;
         1: opc = 7'h13;
         2, 3: opc = 7'h03;
         4: opc = 7'h23;
         5: opc = 7'h63;
         default: opc = 7'($urandom);
      endcase
      return {7'($urandom), rand_reg(), rand_reg(), 3'($urandom), rand_reg(), opc};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      m = '0; m_stall = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      rst = 1; if_valid = 0; if_instr = 0; if_pc = 0;
      wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; ex_ready = 1;

      // reset
      cyc();
      cyc();
      chk("rst_valid", {63'd0, ex_valid}, 64'd0);
      chk("rst_stall", {32'd0, stall_cnt}, 64'd0);
      rst = 0;

      // load x11, x12 then add x12, x11, x12
      wb_we = 1; wb_rd = 11; wb_data = 32'h10; cyc();
      wb_rd = 12; wb_data = 32'h5; cyc();
      wb_we = 0;
      if_valid = 1; if_instr = 32'h00c58633; if_pc = 32'h100; cyc();
      chk("add_dataA", {32'd0, ex_dataA}, 64'h10);
      chk("add_dataB", {32'd0, ex_dataB}, 64'h5);
      chk("add_rd", {59'd0, ex_rd}, 64'd12);
      chk("add_aluop", {62'd0, ex_ALUOp}, 64'd2);
      chk("add_alusrc", {63'd0, ex_ALUSrc}, 64'd0);

      // addi with same-cycle write-back of its source
      if_instr = 32'h00c58593; if_pc = 32'h104;
      wb_we = 1; wb_rd = 11; wb_data = 32'h1234ABCD; cyc();
      wb_we = 0;
      chk("byp_dataA", {32'd0, ex_dataA}, 64'h1234ABCD);
      chk("byp_imm", {32'd0, ex_imm}, 64'hC);

      // lw x12 followed by a dependent add: one bubble
      if_instr = 32'h0045a603; if_pc = 32'h108; cyc();
      if_instr = 32'h00c58633; if_pc = 32'h10c;
      #1 chk("lu_ready", {63'd0, id_ready}, 64'd0);
      cyc();
      chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
      chk("lu_stall", {32'd0, stall_cnt}, 64'd1);
      cyc();
      chk("lu_issue", {32'd0, ex_pc}, 64'h10c);
      chk("lu_stall2", {32'd0, stall_cnt}, 64'd1);

      // beq, then flush with the next instruction offered
      if_instr = 32'h00c58663; if_pc = 32'h110; cyc();
      chk("beq_imm", {32'd0, ex_imm}, 64'hC);
      chk("beq_branch", {63'd0, ex_Branch}, 64'd1);
      flush = 1; if_instr = 32'h00c58633; if_pc = 32'h114; cyc();
      chk("flush_valid", {63'd0, ex_valid}, 64'd0);
      flush = 0; if_valid = 0; cyc();
      chk("flush_lost", {63'd0, ex_valid}, 64'd0);

      // downstream backpressure for 3 cycles, x0 write attempt meanwhile
      if_valid = 1; if_instr = 32'h00c58593; if_pc = 32'h118; cyc();
      ex_ready = 0; if_instr = 32'h00000033; if_pc = 32'h11c;
      wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF;
      for (int k = 0; k < 3; k++) begin
         #1 chk("hold_ready", {63'd0, id_ready}, 64'd0);
         cyc();
         wb_we = 0;
         chk("hold_pc", {32'd0, ex_pc}, 64'h118);
         chk("hold_imm", {32'd0, ex_imm}, 64'hC);
      end
      ex_ready = 1; cyc();
      chk("x0_dataA", {32'd0, ex_dataA}, 64'd0);
      chk("x0_pc", {32'd0, ex_pc}, 64'h11c);

      // reset while holding a load
      if_instr = 32'h0045a603; if_pc = 32'h120; cyc();
      ex_ready = 0; cyc();
      rst = 1; cyc();
      chk("rsthold_valid", {63'd0, ex_valid}, 64'd0);
      rst = 0; ex_ready = 1; if_valid = 0; cyc();
      chk("rsthold_gone", {63'd0, ex_valid}, 64'd0);
      if_valid = 1; if_instr = 32'h00c58593; if_pc = 32'h124; cyc();
      chk("rst_regclr", {32'd0, ex_dataA}, 64'd0);

      // rs1 = x20: out of range only in the 16-register build
      wb_we = 1; wb_rd = 20; wb_data = 32'hABCD; cyc();
      wb_we = 0;
      if_instr = 32'h000A0093; if_pc = 32'h128; cyc();
      chk("e16_valid", {63'd0, ex_valid16}, 64'd1);
      chk("e16_illegal", {63'd0, ex_illegal16}, 64'd1);
      chk("e16_dataA", {32'd0, ex_dataA16}, 64'd0);
      chk("e32_dataA", {32'd0, ex_dataA}, 64'hABCD);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         if_valid = ($urandom_range(0, 3) != 0);
         if_instr = rand_instr();
         if_pc    = $urandom;
         wb_we    = $urandom_range(0, 1) == 1;
         wb_rd    = rand_reg();
         wb_data  = $urandom;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
